axil_periph_bridge: RTL and testbench

- Parametrised AXI4-Lite slave to simple valid/ready peripheral bridge. Successor to the fixed 32-bit single-phase adapter.
- Accepts AW and W independently through one-deep holding registers. Arbitrates reads vs writes round-robin. Returns OKAY/SLVERR responses, with a peripheral error input and an access timeout.
- Sits between the SoC AXI-Lite interconnect and each memory-mapped peripheral.

---
 rtl/axil_periph_bridge.sv | 251 +++++++++++++++++++++++++
 tb/tb_axil_periph_bridge.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_periph_bridge.sv
// AXI4-Lite slave to single-outstanding valid/ready peripheral bridge.
// AW, W and AR are each buffered in a one-deep holding register; reads and
// writes are arbitrated round-robin and each access may end in SLVERR from
// the peripheral error flag or from the access timeout.
module axil_periph_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic [1:0]            s_axi_bresp,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [DATA_W-1:0]     s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  periph_valid,
   input  logic                  periph_ready,
   output logic [ADDR_W-1:0]     periph_addr,
   output logic [DATA_W-1:0]     periph_wdata,
   output logic [DATA_W/8-1:0]   periph_wstrb,
   input  logic [DATA_W-1:0]     periph_rdata,
   input  logic                  periph_err
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit          TMO_EN = (TIMEOUT != 0);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_ACC  = 3'd1;
   localparam logic [2:0] S_RD_ACC  = 3'd2;
   localparam logic [2:0] S_WR_RESP = 3'd3;
   localparam logic [2:0] S_RD_RESP = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              prio_wr_q, prio_wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              aw_h_q, aw_h_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic              w_h_q, w_h_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;
   logic              ar_h_q, ar_h_d;
   logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;

   logic              aw_ready_q, aw_ready_d;
   logic              w_ready_q, w_ready_d;
   logic              ar_ready_q, ar_ready_d;

   logic              pvalid_q, pvalid_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0] pwstrb_q, pwstrb_d;

   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              wr_elig;
   logic              rd_elig;
   logic              tmo_hit;
   logic [1:0]        acc_resp;

   // Next-state logic: holding-register capture, arbitration, access and response phases
   always_comb begin
      state_d    = state_q;
      prio_wr_d  = prio_wr_q;
      cnt_d      = cnt_q;
      aw_h_d     = aw_h_q;
      aw_addr_d  = aw_addr_q;
      w_h_d      = w_h_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      ar_h_d     = ar_h_q;
      ar_addr_d  = ar_addr_q;
      pvalid_d   = pvalid_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      pwstrb_d   = pwstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      wr_elig    = aw_h_q && w_h_q;
      rd_elig    = ar_h_q;
      tmo_hit    = TMO_EN && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));
      acc_resp   = RESP_OKAY;

      // A channel is only accepted into an empty holding register
      if (s_axi_awvalid && !aw_h_q) begin
         aw_h_d    = 1'b1;
         aw_addr_d = s_axi_awaddr;
      end
      if (s_axi_wvalid && !w_h_q) begin
         w_h_d    = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end
      if (s_axi_arvalid && !ar_h_q) begin
         ar_h_d    = 1'b1;
         ar_addr_d = s_axi_araddr;
      end

      case (state_q)
         S_IDLE: begin
            if (wr_elig && (!rd_elig || prio_wr_q)) begin
               aw_h_d   = 1'b0;
               w_h_d    = 1'b0;
               pvalid_d = 1'b1;
               paddr_d  = aw_addr_q;
               pwdata_d = w_data_q;
               pwstrb_d = w_strb_q;
               cnt_d    = '0;
               state_d  = S_WR_ACC;
               // Priority only moves when the other side was also waiting
               if (rd_elig) prio_wr_d = 1'b0;
            end else if (rd_elig) begin
               ar_h_d   = 1'b0;
               pvalid_d = 1'b1;
               paddr_d  = ar_addr_q;
               pwdata_d = w_data_q;
               pwstrb_d = '0;
               cnt_d    = '0;
               state_d  = S_RD_ACC;
               if (wr_elig) prio_wr_d = 1'b1;
            end
         end
         S_WR_ACC, S_RD_ACC: begin
            // periph_ready has precedence over a timeout in the same cycle
            if (periph_ready || tmo_hit) begin
               acc_resp = (periph_ready && !periph_err) ? RESP_OKAY : RESP_SLVERR;
               pvalid_d = 1'b0;
               if (state_q == S_WR_ACC) begin
                  bvalid_d = 1'b1;
                  bresp_d  = acc_resp;
                  state_d  = S_WR_RESP;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = acc_resp;
                  rdata_d  = periph_ready ? periph_rdata : '0;
                  state_d  = S_RD_RESP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR_RESP: begin
            if (s_axi_bready) begin
               bvalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_RD_RESP: begin
            if (s_axi_rready) begin
               rvalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      aw_ready_d = !aw_h_d;
      w_ready_d  = !w_h_d;
      ar_ready_d = !ar_h_d;
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         prio_wr_q  <= 1'b1;
         cnt_q      <= '0;
         aw_h_q     <= 1'b0;
         aw_addr_q  <= '0;
         w_h_q      <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         ar_h_q     <= 1'b0;
         ar_addr_q  <= '0;
         aw_ready_q <= 1'b1;
         w_ready_q  <= 1'b1;
         ar_ready_q <= 1'b1;
         pvalid_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         pwstrb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         prio_wr_q  <= prio_wr_d;
         cnt_q      <= cnt_d;
         aw_h_q     <= aw_h_d;
         aw_addr_q  <= aw_addr_d;
         w_h_q      <= w_h_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         ar_h_q     <= ar_h_d;
         ar_addr_q  <= ar_addr_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         ar_ready_q <= ar_ready_d;
         pvalid_q   <= pvalid_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         pwstrb_q   <= pwstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   assign s_axi_awready = aw_ready_q;
   assign s_axi_wready  = w_ready_q;
   assign s_axi_arready = ar_ready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign periph_valid  = pvalid_q;
   assign periph_addr   = paddr_q;
   assign periph_wdata  = pwdata_q;
   assign periph_wstrb  = pwstrb_q;

endmodule

// File: tb/tb_axil_periph_bridge.sv
// Scoreboard bench for axil_periph_bridge: an AXI-Lite master, a peripheral
// model that decides each access outcome and predicts the AXI response, and
// independent B/R monitors that pop and compare on every handshake.
module tb_axil_periph_bridge;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;
   localparam int          TMO = 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
   } wr_t;

   typedef struct packed {
      logic [1:0]    resp;
      logic [DW-1:0] data;
   } rsp_t;

   logic          clk;
   logic          reset;
   logic          s_axi_awvalid, s_axi_awready;
   logic [AW-1:0] s_axi_awaddr;
   logic          s_axi_wvalid, s_axi_wready;
   logic [DW-1:0] s_axi_wdata;
   logic [SW-1:0] s_axi_wstrb;
   logic          s_axi_bvalid, s_axi_bready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_arvalid, s_axi_arready;
   logic [AW-1:0] s_axi_araddr;
   logic          s_axi_rvalid, s_axi_rready;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          periph_valid, periph_ready, periph_err;
   logic [AW-1:0] periph_addr;
   logic [DW-1:0] periph_wdata, periph_rdata;
   logic [SW-1:0] periph_wstrb;

   axil_periph_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp),
      .periph_valid(periph_valid), .periph_ready(periph_ready), .periph_addr(periph_addr),
      .periph_wdata(periph_wdata), .periph_wstrb(periph_wstrb), .periph_rdata(periph_rdata),
      .periph_err(periph_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected traffic
   wr_t           exp_wr[$];
   logic [AW-1:0] exp_rd[$];
   logic [1:0]    exp_b[$];
   rsp_t          exp_r[$];
   bit            launch_log[$];

   int checks = 0;
   int errors = 0;

   // Peripheral behaviour controls, written only by the main sequence
   int            p_fixed = -1;   // -1: random delay, otherwise cycles before ready
   bit            p_dir = 1'b0;   // use directed rdata/err instead of random
   logic [DW-1:0] p_dir_rdata = '0;
   bit            p_dir_err = 1'b0;
   bit            r_stall = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Master channel drivers; all called just after a rising edge
   task automatic do_aw(input logic [AW-1:0] a);
      int n = 0;
      bit rdy;
      s_axi_awvalid = 1'b1;
      s_axi_awaddr  = a;
      do begin
         @(negedge clk); rdy = s_axi_awready;
         @(posedge clk); n++;
      end while (!rdy && n < 300);
      chk("aw_handshake", rdy, 1);
      #1 s_axi_awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
      int n = 0;
      bit rdy;
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = d;
      s_axi_wstrb  = s;
      do begin
         @(negedge clk); rdy = s_axi_wready;
         @(posedge clk); n++;
      end while (!rdy && n < 300);
      chk("w_handshake", rdy, 1);
      #1 s_axi_wvalid = 1'b0;
   endtask

   task automatic do_ar(input logic [AW-1:0] a);
      int n = 0;
      bit rdy;
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = a;
      do begin
         @(negedge clk); rdy = s_axi_arready;
         @(posedge clk); n++;
      end while (!rdy && n < 300);
      chk("ar_handshake", rdy, 1);
      #1 s_axi_arvalid = 1'b0;
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      wr_t t;
      t.addr = a; t.data = d; t.strb = s;
      exp_wr.push_back(t);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                     input int da, input int dw);
      push_wr(a, d, s);
      fork
         begin
            if (da > 0) begin repeat (da) @(posedge clk); #1; end
            do_aw(a);
         end
         begin
            if (dw > 0) begin repeat (dw) @(posedge clk); #1; end
            do_w(d, s);
         end
      join
   endtask

   task automatic rd(input logic [AW-1:0] a, input int da);
      exp_rd.push_back(a);
      if (da > 0) begin repeat (da) @(posedge clk); #1; end
      do_ar(a);
   endtask

   task automatic wait_quiet(input int max_cycles);
      int n = 0;
      bit quiet;
      quiet = 1'b0;
      while (!quiet && n < max_cycles) begin
         @(negedge clk); n++;
         quiet = (exp_wr.size() == 0) && (exp_rd.size() == 0) && (exp_b.size() == 0) &&
                 (exp_r.size() == 0) && !periph_valid && !s_axi_bvalid && !s_axi_rvalid;
      end
      chk("drain", quiet, 1);
      @(posedge clk); #1;
   endtask

   // Response ready drivers
   initial begin
      s_axi_bready = 1'b0;
      s_axi_rready = 1'b0;
      forever begin
         @(posedge clk); #1;
         s_axi_bready = ($urandom_range(0, 3) != 0);
         s_axi_rready = r_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Peripheral model: checks each request and predicts the AXI response
   initial begin : periph_model
      int            d, cyc;
      bit            is_wr, aborted, err;
      logic [DW-1:0] rd_val;
      logic [AW-1:0] a0;
      logic [SW-1:0] s0;
      wr_t           ew;
      logic [AW-1:0] ea;
      rsp_t          rr;
      periph_ready = 1'b0;
      periph_err   = 1'b0;
      periph_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset || !periph_valid) continue;
         is_wr = (periph_wstrb != '0);
         launch_log.push_back(is_wr);
         if (is_wr) begin
            chk("periph_wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
               ew = exp_wr.pop_front();
               chk("periph_wr_addr", periph_addr, ew.addr);
               chk("periph_wr_data", periph_wdata, ew.data);
               chk("periph_wr_strb", periph_wstrb, ew.strb);
            end
         end else begin
            chk("periph_rd_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
               ea = exp_rd.pop_front();
               chk("periph_rd_addr", periph_addr, ea);
            end
         end
         d      = (p_fixed >= 0) ? p_fixed : int'($urandom_range(0, 9));
         rd_val = p_dir ? p_dir_rdata : DW'($urandom);
         err    = p_dir ? p_dir_err : ($urandom_range(0, 3) == 0);
         a0 = periph_addr; s0 = periph_wstrb;
         cyc = 1; aborted = 1'b0;
         forever begin
            if (cyc == d + 1) begin
               periph_ready = 1'b1; periph_err = err; periph_rdata = rd_val;
               @(posedge clk);
               rr.resp = err ? 2'b10 : 2'b00;
               rr.data = rd_val;
               if (is_wr) exp_b.push_back(rr.resp); else exp_r.push_back(rr);
               #1 periph_ready = 1'b0; periph_err = 1'b0; periph_rdata = DW'($urandom);
               break;
            end
            if (cyc == TMO) begin
               @(posedge clk);
               rr.resp = 2'b10;
               rr.data = '0;
               if (is_wr) exp_b.push_back(rr.resp); else exp_r.push_back(rr);
               break;
            end
            @(negedge clk); cyc++;
            if (reset) begin aborted = 1'b1; break; end
            chk("periph_valid_held", periph_valid, 1);
            chk("periph_addr_stable", periph_addr, a0);
            chk("periph_strb_stable", periph_wstrb, s0);
         end
         if (!aborted) begin
            @(negedge clk);
            chk("periph_valid_drop", periph_valid, 0);
         end
      end
   end

   // Write response monitor
   initial begin : b_mon
      bit         pend;
      logic [1:0] prev;
      pend = 1'b0; prev = '0;
      forever begin
         @(negedge clk);
         if (reset || !s_axi_bvalid) begin pend = 1'b0; continue; end
         if (pend) chk("bresp_stable", s_axi_bresp, prev);
         if (s_axi_bready) begin
            chk("b_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) chk("bresp", s_axi_bresp, exp_b.pop_front());
            pend = 1'b0;
         end else begin
            pend = 1'b1; prev = s_axi_bresp;
         end
      end
   end

   // Read response monitor
   initial begin : r_mon
      bit   pend;
      rsp_t prev, e;
      pend = 1'b0; prev = '0;
      forever begin
         @(negedge clk);
         if (reset || !s_axi_rvalid) begin pend = 1'b0; continue; end
         if (pend) begin
            chk("rresp_stable", s_axi_rresp, prev.resp);
            chk("rdata_stable", s_axi_rdata, prev.data);
         end
         if (s_axi_rready) begin
            chk("r_expected", exp_r.size() > 0, 1);
            if (exp_r.size() > 0) begin
               e = exp_r.pop_front();
               chk("rresp", s_axi_rresp, e.resp);
               chk("rdata", s_axi_rdata, e.data);
            end
            pend = 1'b0;
         end else begin
            pend = 1'b1; prev.resp = s_axi_rresp; prev.data = s_axi_rdata;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   // Main sequence
   initial begin : main
      bit order[4];
      int n;
      order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b0; order[3] = 1'b1;
      reset = 1'b1;
      s_axi_awvalid = 1'b0; s_axi_awaddr = '0;
      s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_arvalid = 1'b0; s_axi_araddr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", s_axi_awready, 1);
      chk("rst_wready", s_axi_wready, 1);
      chk("rst_arready", s_axi_arready, 1);
      chk("rst_bvalid", s_axi_bvalid, 0);
      chk("rst_rvalid", s_axi_rvalid, 0);
      chk("rst_periph_valid", periph_valid, 0);
      chk("rst_rdata", s_axi_rdata, 0);
      chk("rst_periph_addr", periph_addr, 0);
      chk("rst_periph_wstrb", periph_wstrb, 0);
      chk("rst_bresp", s_axi_bresp, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Write with AW and W together
      p_dir = 1'b1; p_dir_err = 1'b0; p_dir_rdata = '0; p_fixed = 1;
      wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      wait_quiet(100);
      chk("t1_awready", s_axi_awready, 1);
      chk("t1_wready", s_axi_wready, 1);

      // W three cycles ahead of AW
      p_fixed = 0;
      push_wr(32'h20, 32'h1234, 4'h3);
      do_w(32'h1234, 4'h3);
      @(negedge clk);
      chk("t2_wready_low", s_axi_wready, 0);
      chk("t2_no_launch", periph_valid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t2_no_launch_late", periph_valid, 0);
      @(posedge clk); #1;
      do_aw(32'h20);
      wait_quiet(100);

      // Read with peripheral error and a stalled rready
      p_dir = 1'b1; p_dir_rdata = 32'hCAFEF00D; p_dir_err = 1'b1; p_fixed = 2;
      r_stall = 1'b1;
      rd(32'h30, 0);
      n = 0;
      while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
      chk("t3_rvalid_seen", s_axi_rvalid, 1);
      repeat (4) begin
         @(negedge clk);
         chk("t3_rvalid_held", s_axi_rvalid, 1);
         chk("t3_rdata_held", s_axi_rdata, 32'hCAFEF00D);
         chk("t3_rresp_held", s_axi_rresp, 2'b10);
      end
      @(posedge clk); #1;
      r_stall = 1'b0;
      wait_quiet(100);
      p_dir = 1'b0;

      // Two contested rounds: write first, then read first
      p_fixed = 2;
      launch_log.delete();
      fork
         wr(32'h40, DW'($urandom), 4'hF, 0, 0);
         rd(32'h44, 0);
      join
      wait_quiet(200);
      fork
         wr(32'h48, DW'($urandom), 4'hF, 0, 0);
         rd(32'h4C, 0);
      join
      wait_quiet(200);
      chk("t4_launch_count", launch_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < launch_log.size()) chk($sformatf("t4_order_%0d", i), launch_log[i], order[i]);

      // Timeouts: read with no ready, read with ready on the last cycle, write with no ready
      p_fixed = 100;
      rd(32'h50, 0);
      wait_quiet(200);
      p_dir = 1'b1; p_dir_rdata = 32'h5555AAAA; p_dir_err = 1'b0; p_fixed = TMO - 1;
      rd(32'h54, 0);
      wait_quiet(200);
      p_dir = 1'b0; p_fixed = 100;
      wr(32'h58, 32'h0BADF00D, 4'hC, 0, 0);
      wait_quiet(200);

      // Reset in the middle of a write access
      p_fixed = 100;
      wr(32'h60, 32'h600D600D, 4'hF, 0, 0);
      n = 0;
      while (!periph_valid && n < 50) begin @(negedge clk); n++; end
      chk("t6_launched", periph_valid, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1 chk("t6_async_drop", periph_valid, 0);
      repeat (2) @(negedge clk);
      exp_wr.delete(); exp_rd.delete();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_awready", s_axi_awready, 1);
      chk("t6_wready", s_axi_wready, 1);
      chk("t6_arready", s_axi_arready, 1);
      chk("t6_bvalid", s_axi_bvalid, 0);
      @(posedge clk); #1;
      p_fixed = -1;
      rd(32'h64, 0);
      wait_quiet(200);

      // Randomised mixed traffic
      for (int i = 0; i < 60; i++) begin
         int op;
         logic [AW-1:0] a;
         op = int'($urandom_range(0, 2));
         a  = AW'($urandom) & ~AW'(3);
         if (op == 0)
            wr(a, DW'($urandom), SW'($urandom_range(1, 15)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else if (op == 1)
            rd(a, int'($urandom_range(0, 3)));
         else
            fork
               wr(a, DW'($urandom), SW'($urandom_range(1, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
               rd(a ^ AW'(32'h100), int'($urandom_range(0, 3)));
            join
      end
      wait_quiet(500);

      chk("leftover_expectations",
          exp_wr.size() + exp_rd.size() + exp_b.size() + exp_r.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
